// File: rtl/chip7458_tester_pkg.sv
// Shared definitions for the chip7458 exhaustive tester: FSM encoding,
// vector-space size and the vector-bit to drive-pin map.
package chip7458_tester_pkg;

    localparam int NUM_VECTORS = 1024;
    localparam int VEC_W       = 10;
    localparam int CNT_W       = 4;
    localparam int ERR_W       = 11;

    localparam logic [VEC_W-1:0] LAST_VEC = 10'(NUM_VECTORS - 1);

    localparam int P1A_BIT = 0;
    localparam int P1B_BIT = 1;
    localparam int P1C_BIT = 2;
    localparam int P1D_BIT = 3;
    localparam int P1E_BIT = 4;
    localparam int P1F_BIT = 5;
    localparam int P2A_BIT = 6;
    localparam int P2B_BIT = 7;
    localparam int P2C_BIT = 8;
    localparam int P2D_BIT = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic is_active(input state_t s);
        return (s == ST_DRIVE) || (s == ST_SETTLE) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/chip7458.sv
// Behavioural chip7458 dual AND-OR gate; used as the tester's golden model.
module chip7458 (
    input  logic p1a,
    input  logic p1b,
    input  logic p1c,
    input  logic p1d,
    input  logic p1e,
    input  logic p1f,
    input  logic p2a,
    input  logic p2b,
    input  logic p2c,
    input  logic p2d,
    output logic p1y,
    output logic p2y
);

    assign p1y = (p1a & p1b & p1c) | (p1d & p1e & p1f);
    assign p2y = (p2a & p2b) | (p2c & p2d);

endmodule

// File: rtl/chip7458_tester.sv
// Exhaustive tester: walks all 1024 input vectors into an external chip7458,
// compares its outputs with a golden instance and records mismatches.
module chip7458_tester
    import chip7458_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_p1y,
    input  logic             dut_p2y,
    output logic             p1a,
    output logic             p1b,
    output logic             p1c,
    output logic             p1d,
    output logic             p1e,
    output logic             p1f,
    output logic             p2a,
    output logic             p2b,
    output logic             p2c,
    output logic             p2d,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [VEC_W-1:0] fail_vec,
    output logic [ERR_W-1:0] err_count
);

    localparam logic             HAS_SETTLE  = 1'(SETTLE_CYCLES > 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    state_t             state_r;
    state_t             state_s;
    logic [VEC_W-1:0]   v_r;
    logic [VEC_W-1:0]   vec_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [VEC_W-1:0]   pins_r;
    logic               busy_r;
    logic               done_r;
    logic               fail_r;
    logic [VEC_W-1:0]   fail_vec_r;
    logic [ERR_W-1:0]   err_count_r;
    logic               start_run_s;
    logic               next_vec_s;
    logic               exp_p1y_s;
    logic               exp_p2y_s;
    logic               mismatch_s;

    chip7458 u_golden (
        .p1a (v_r[P1A_BIT]),
        .p1b (v_r[P1B_BIT]),
        .p1c (v_r[P1C_BIT]),
        .p1d (v_r[P1D_BIT]),
        .p1e (v_r[P1E_BIT]),
        .p1f (v_r[P1F_BIT]),
        .p2a (v_r[P2A_BIT]),
        .p2b (v_r[P2B_BIT]),
        .p2c (v_r[P2C_BIT]),
        .p2d (v_r[P2D_BIT]),
        .p1y (exp_p1y_s),
        .p2y (exp_p2y_s)
    );

    assign mismatch_s = (dut_p1y != exp_p1y_s) || (dut_p2y != exp_p2y_s);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic plus run-start and vector-advance strobes
    always_comb begin
        state_s     = state_r;
        start_run_s = 1'b0;
        next_vec_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s     = ST_DRIVE;
                    start_run_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DRIVE: begin
                if (HAS_SETTLE) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (v_r == LAST_VEC) begin
                    state_s = ST_DONE;
                end else begin
                    state_s    = ST_DRIVE;
                    next_vec_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next vector index: cleared on a new run, stepped after each CHECK
    always_comb begin
        vec_s = v_r;
        if (start_run_s) begin
            vec_s = {VEC_W{1'b0}};
        end else if (next_vec_s) begin
            vec_s = v_r + 10'd1;
        end else begin
            vec_s = v_r;
        end
    end

    // Datapath: vector, settle counter, drive pins and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r         <= {VEC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            pins_r      <= {VEC_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            fail_vec_r  <= {VEC_W{1'b0}};
            err_count_r <= {ERR_W{1'b0}};
        end else begin
            v_r    <= vec_s;
            busy_r <= is_active(state_s);
            done_r <= (state_s == ST_DONE);
            // pins only change on entry to DRIVE, so they hold through SETTLE/CHECK/DONE
            if (state_s == ST_DRIVE) begin
                pins_r <= vec_s;
            end
            if (state_r == ST_SETTLE) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            if (start_run_s) begin
                fail_r      <= 1'b0;
                fail_vec_r  <= {VEC_W{1'b0}};
                err_count_r <= {ERR_W{1'b0}};
            end else if ((state_r == ST_CHECK) && mismatch_s) begin
                err_count_r <= err_count_r + 11'd1;
                if (!fail_r) begin
                    fail_r     <= 1'b1;
                    fail_vec_r <= v_r;
                end
            end
        end
    end

    assign p1a       = pins_r[P1A_BIT];
    assign p1b       = pins_r[P1B_BIT];
    assign p1c       = pins_r[P1C_BIT];
    assign p1d       = pins_r[P1D_BIT];
    assign p1e       = pins_r[P1E_BIT];
    assign p1f       = pins_r[P1F_BIT];
    assign p2a       = pins_r[P2A_BIT];
    assign p2b       = pins_r[P2B_BIT];
    assign p2c       = pins_r[P2C_BIT];
    assign p2d       = pins_r[P2D_BIT];
    assign busy      = busy_r;
    assign done      = done_r;
    assign fail      = fail_r;
    assign fail_vec  = fail_vec_r;
    assign err_count = err_count_r;

endmodule
